// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-output bundle for seq_frame_tx.
// The master side drives payload words; the slave side is the framer.
interface seq_frame_tx_if #(
    parameter int PAYLOAD_W = 8
);
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_ready;
    logic                 data;
    logic                 busy;
    logic                 done;

    modport master (
        output in_valid, in_payload,
        input  in_ready, data, busy, done
    );

    modport slave (
        input  in_valid, in_payload,
        output in_ready, data, busy, done
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial framer: emits preamble 1101, then the captured payload MSB first, one bit per clk.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit (PAR state) after the payload.
module seq_frame_tx #(
    parameter int PAYLOAD_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    seq_frame_tx_if.slave bus
);
    // Wide enough for the payload count, and never narrower than the 4-bit preamble index.
    localparam int CNT_W = ($clog2(PAYLOAD_W + 1) < 2) ? 2 : $clog2(PAYLOAD_W + 1);
    localparam logic [3:0] PRE_BITS = 4'b1101;

`ifdef SEQ_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, PRE, PAY, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRE, PAY} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0] sr_q, sr_d;
    logic                 data_q, data_d;
    logic                 done_q, done_d;
    logic [1:0]           pre_idx;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // state_q always names the field whose bit is currently on data_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = 1'b0;
        done_d  = 1'b0;
        pre_idx = 2'd2 - cnt_q[1:0];
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    sr_d    = bus.in_payload;
                    data_d  = PRE_BITS[3];
`ifdef SEQ_FRAME_TX_PARITY_EN
                    par_d   = ^bus.in_payload;
`endif
                end
            end
            PRE: begin
                if (cnt_q == CNT_W'(3)) begin
                    state_d = PAY;
                    cnt_d   = CNT_W'(PAYLOAD_W - 1);
                    data_d  = sr_q[PAYLOAD_W-1];
                    sr_d    = sr_q << 1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    data_d  = PRE_BITS[pre_idx];
                end
            end
            PAY: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    data_d = sr_q[PAYLOAD_W-1];
                    sr_d   = sr_q << 1;
                end else begin
                    cnt_d = '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    state_d = PAR;
                    data_d  = par_q;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.data     = data_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: table of payload frames plus back-to-back, reset-abort and loopback sequences.
module tb_seq_frame_tx;
    localparam int PW = 8;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    seq_frame_tx_if #(.PAYLOAD_W(PW)) bus ();
    seq_frame_tx #(.PAYLOAD_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 1101 detector fed from the serial output.
    logic [3:0] det_sr;
    logic       start_shifting;
    always @(posedge clk) begin
        if (reset) det_sr <= 4'b0000;
        else       det_sr <= {det_sr[2:0], bus.data};
    end
    assign start_shifting = (det_sr == 4'b1101);

    typedef struct {
        logic [7:0]  payload;
        logic [11:0] bits;
        logic        par;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Call just after an accept edge; checks every frame bit and the trailing done cycle.
    task automatic check_frame(input logic [11:0] bits, input logic par, input bit chk_det);
        logic expb;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            expb = (i < 12) ? bits[11-i] : par;
            chk($sformatf("data[%0d]", i), {31'b0, bus.data}, {31'b0, expb});
            chk($sformatf("busy[%0d]", i), {31'b0, bus.busy}, 32'd1);
            chk($sformatf("in_ready[%0d]", i), {31'b0, bus.in_ready}, 32'd0);
            chk($sformatf("done_mid[%0d]", i), {31'b0, bus.done}, 32'd0);
            if (chk_det)
                chk($sformatf("start_shifting[%0d]", i), {31'b0, start_shifting}, (i == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", {31'b0, bus.done}, 32'd1);
        chk("done_data", {31'b0, bus.data}, 32'd0);
        chk("done_busy", {31'b0, bus.busy}, 32'd0);
        chk("done_ready", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] pl, input logic [11:0] bits, input logic par, input bit chk_det);
        wait_ready();
        bus.in_valid   = 1'b1;
        bus.in_payload = pl;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check_frame(bits, par, chk_det);
        @(negedge clk);
        chk("done_single", {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{8'hA5, 12'b1101_1010_0101, 1'b0};
        vecs[1] = '{8'h07, 12'b1101_0000_0111, 1'b1};
        vecs[2] = '{8'h3C, 12'b1101_0011_1100, 1'b0};
        vecs[3] = '{8'hFF, 12'b1101_1111_1111, 1'b0};
        vecs[4] = '{8'h80, 12'b1101_1000_0000, 1'b1};
        vecs[5] = '{8'h01, 12'b1101_0000_0001, 1'b1};

        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_data", {31'b0, bus.data}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);

        foreach (vecs[k]) send_frame(vecs[k].payload, vecs[k].bits, vecs[k].par, 1'b0);

        // Back-to-back with in_valid held; payload changes mid-frame must be ignored.
        wait_ready();
        bus.in_valid   = 1'b1;
        bus.in_payload = 8'h3C;
        @(posedge clk);
        #1 bus.in_payload = 8'hC3;
        check_frame(12'b1101_0011_1100, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.in_payload = 8'h00;
        check_frame(12'b1101_1100_0011, 1'b0, 1'b0);

        // Reset in the 6th frame cycle aborts the frame without done.
        wait_ready();
        bus.in_valid   = 1'b1;
        bus.in_payload = 8'hA5;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_c6_data", {31'b0, bus.data}, 32'd0);
        chk("abort_c6_busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_data", {31'b0, bus.data}, 32'd0);
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone[%0d]", i), {31'b0, bus.done}, 32'd0);
            chk($sformatf("abort_idle_data[%0d]", i), {31'b0, bus.data}, 32'd0);
        end

        // Reset wins over a simultaneous accept.
        reset          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_payload = 8'h55;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("prio_busy", {31'b0, bus.busy}, 32'd0);
        chk("prio_data", {31'b0, bus.data}, 32'd0);
        chk("prio_ready", {31'b0, bus.in_ready}, 32'd1);

        send_frame(8'hFF, 12'b1101_1111_1111, 1'b0, 1'b0);

        // Loopback into the reference detector.
        send_frame(8'h00, 12'b1101_0000_0000, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 8, payload bits sent per frame (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  payload word offered.
REQ-005 SHALL have port in_payload  input  PAYLOAD_W  payload word, sent MSB first.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port data  output  1  serial stream for the 1101 sequence detector, one bit per clk.
REQ-008 SHALL have port busy  output  1  frame in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-010 SHALL implement states IDLE, PRE, PAY, PAR (PAR only with the REQ-026 macro).
REQ-011 SHALL assert in_ready only in IDLE; in_ready SHALL NOT depend combinationally on in_valid.
REQ-012 SHALL accept a word on the edge where in_valid && in_ready, capture in_payload into an internal shift register, and move to PRE.
REQ-013 SHALL ignore in_valid and in_payload changes while not in IDLE; the captured word SHALL NOT change mid-frame.
REQ-014 SHALL drive data = 0 in IDLE.
REQ-015 SHALL drive the preamble 1,1,0,1 on data in the 4 cycles following the accept edge; the first preamble bit SHALL appear in the cycle immediately after the accept edge.
REQ-016 SHALL drive the PAYLOAD_W payload bits MSB first in the PAYLOAD_W cycles directly after the last preamble bit, with no gap.
REQ-017 SHALL register data so that it is glitch-free and changes only on clk edges.
REQ-018 SHALL track preamble and payload positions with a bit counter sized ceil(log2(PAYLOAD_W+1)); the counter SHALL NOT wrap within a frame.
REQ-019 SHALL return to IDLE on the edge that ends the final frame bit.
REQ-020 SHALL pulse done high for exactly one cycle, namely the first IDLE cycle after a frame.
REQ-021 SHALL assert in_ready in that same cycle, so back-to-back frames are separated by exactly one idle data=0 cycle.
REQ-022 SHALL assert busy in PRE, PAY and PAR, and deassert it in IDLE.
REQ-023 SHALL NOT suppress or escape 1101 patterns inside the payload; the downstream protocol is responsible for framing.

Reset
REQ-024 SHALL, when reset = 1 at a clk edge, go to IDLE, clear the counter and shift register, and drive data=0, busy=0, done=0 and in_ready=1 in the following cycle.
REQ-025 SHALL abort any frame in progress when reset is asserted mid-frame, emit no done, and discard the captured word; reset SHALL take priority over an accept in the same cycle.

Configuration
REQ-026 SHALL include a parity bit only when macro SEQ_FRAME_TX_PARITY_EN is defined.
- Defined: state PAR follows PAY for 1 cycle and drives data = XOR of all captured payload bits (even parity); frame length = 4 + PAYLOAD_W + 1 cycles.
- Not defined: no PAR state and no parity logic; frame length = 4 + PAYLOAD_W cycles.

Verification
REQ-027 SHALL pass: reset for 2 cycles then release -> data=0, busy=0, done=0, in_ready=1.
REQ-028 SHALL pass (PAYLOAD_W=8, macro off): accept 0xA5 -> data = 1,1,0,1,1,0,1,0,0,1,0,1 over 12 cycles, then done=1 for 1 cycle with data=0.
REQ-029 SHALL pass (macro on): accept 0xA5 -> the same 12 bits followed by parity 0; accept 0x07 -> parity 1; done occurs 13 cycles after accept.
REQ-030 SHALL pass: in_valid held high with 0x3C and then 0xC3 -> two frames with exactly one data=0 gap cycle between them; in_ready=1 only in IDLE cycles.
REQ-031 SHALL pass: reset asserted in the 6th frame cycle -> data=0 and busy=0 the next cycle, no done pulse, and a following accept of 0xFF sends a complete fresh frame.
REQ-032 SHALL pass: a loopback to the 1101 detector, sending 0x00 -> start_shifting rises after the 4th preamble bit.
